// File: rtl/and_result_skid_pkg.sv
// Shared definitions for the AND-result skid stage.
//   occ_e          : buffer occupancy encoding (EMPTY/ONE/TWO; 2'd3 unused)
//   DEF_WIDTH      : default data width, matches the upstream AND block
//   DEF_CNT_W      : default statistics counter width
`ifndef AND_RESULT_SKID_PKG_SV
`define AND_RESULT_SKID_PKG_SV
package and_result_skid_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_CNT_W = 8;

endpackage
`endif

// File: rtl/and_result_skid_stats.sv
// Saturating traffic statistics for accepted beats.
//   clk, rst_n : clock, asynchronous active-low reset
//   accept     : a beat is accepted this cycle
//   data       : the accepted beat (ignored when accept is low)
//   xfer_cnt   : number of accepted beats, saturating
//   ones_cnt   : total set bits across accepted beats, saturating
//   all_ones   : sticky, some accepted beat had every bit set
module and_result_stats
  import and_result_skid_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             all_ones
);

  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             all_q, all_d;

  function automatic logic [CNT_W:0] popcount(input logic [WIDTH-1:0] d);
    logic [CNT_W:0] pc;
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + {{CNT_W{1'b0}}, d[i]};
    end
    return pc;
  endfunction

  // Add at CNT_W+1 bits; a carry out means overflow, so clamp to all-ones.
  // A saturated counter can never drop back because the increment is >= 0.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0]   b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + b;
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Data only enters the arithmetic under accept, so X on an idle bus
  // cannot reach the counters.
  always_comb begin
    xfer_d = xfer_q;
    ones_d = ones_q;
    all_d  = all_q;
    if (accept) begin
      xfer_d = sat_add(xfer_q, {{CNT_W{1'b0}}, 1'b1});
      ones_d = sat_add(ones_q, popcount(data));
      all_d  = all_q | (&data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q <= '0;
      ones_q <= '0;
      all_q  <= 1'b0;
    end else begin
      xfer_q <= xfer_d;
      ones_q <= ones_d;
      all_q  <= all_d;
    end
  end

  assign xfer_cnt = xfer_q;
  assign ones_cnt = ones_q;
  assign all_ones = all_q;

endmodule

// File: rtl/and_result_skid.sv
// Registered 2-entry skid buffer for AND results with traffic statistics.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : producer handshake (in_ready registered)
//   in_data             : AND result from upstream
//   out_valid/out_ready : consumer handshake (out_valid from occupancy)
//   out_data            : head entry, straight from a flop
//   xfer_cnt, ones_cnt  : saturating accepted-beat / set-bit counters
//   all_ones            : sticky all-bits-set flag
module and_result_skid
  import and_result_skid_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             all_ones
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             pop;

  assign out_valid = (state_q == OCC_ONE) || (state_q == OCC_TWO);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      OCC_ONE: begin
        if (accept && !pop) begin
          state_d = OCC_TWO;
          tail_d  = in_data;
        end else if (pop && !accept) begin
          state_d = OCC_EMPTY;
        end else if (accept && pop) begin
          head_d  = in_data;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          state_d = OCC_ONE;
          head_d  = tail_q;
        end
      end
      // EMPTY, and the unused encoding 2'd3 recovers as EMPTY.
      default: begin
        if (accept) begin
          state_d = OCC_ONE;
          head_d  = in_data;
        end
      end
    endcase
    // Registered ready: looks at the next occupancy so it is correct
    // in the cycle the buffer fills or drains.
    in_ready_d = (state_d != OCC_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = head_q;

  and_result_stats #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .data     (in_data),
    .xfer_cnt (xfer_cnt),
    .ones_cnt (ones_cnt),
    .all_ones (all_ones)
  );

endmodule

// File: tb/tb_and_result_skid.sv
module tb_and_result_skid;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_ready;
  logic [7:0] xfer_cnt;
  logic [7:0] ones_cnt;
  logic       all_ones;

  // Small-counter instance for saturation checks.
  logic       s_in_valid;
  logic [1:0] s_in_data;
  logic       s_in_ready;
  logic       s_out_valid;
  logic [1:0] s_out_data;
  logic       s_out_ready;
  logic [2:0] s_xfer_cnt;
  logic [2:0] s_ones_cnt;
  logic       s_all_ones;

  int tests_run = 0;
  int tests_failed = 0;

  and_result_skid #(.WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt), .ones_cnt(ones_cnt), .all_ones(all_ones)
  );

  and_result_skid #(.WIDTH(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .xfer_cnt(s_xfer_cnt), .ones_cnt(s_ones_cnt), .all_ones(s_all_ones)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 2'b00;
    out_ready = 1'b0;
    s_in_valid = 1'b0;
    s_in_data = 2'b00;
    s_out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 2'b11;
    out_ready = 1'b0;
    s_in_valid = 1'b0;
    s_in_data = 2'b00;
    s_out_ready = 1'b0;
    step();
    step();
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    tests_run++;
    if (out_data !== 2'b00) begin
      tests_failed++; $display("FAIL reset_out_data: got %b want 00", out_data);
    end
    tests_run++;
    if (xfer_cnt !== 8'd0 || ones_cnt !== 8'd0 || all_ones !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stats: got xfer=%0d ones=%0d all=%b want 0 0 0", xfer_cnt, ones_cnt, all_ones);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_first_beat: got v=%b d=%b want v=1 d=11", out_valid, out_data);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || xfer_cnt !== 8'd1 || ones_cnt !== 8'd2 || all_ones !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_drain: got v=%b xfer=%0d ones=%0d all=%b want 0 1 2 1", out_valid, xfer_cnt, ones_cnt, all_ones);
    end
  endtask

  task automatic test_streaming();
    logic [1:0] beats [4];
    beats[0] = 2'b01; beats[1] = 2'b10; beats[2] = 2'b11; beats[3] = 2'b00;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = beats[i];
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
      end
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== beats[i]) begin
        tests_failed++;
        $display("FAIL stream_out[%0d]: got v=%b d=%b want v=1 d=%b", i, out_valid, out_data, beats[i]);
      end
    end
    // Idle bus carries X; it must not disturb any state.
    in_valid = 1'b0;
    in_data = 2'bxx;
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stream_empty: got %b want 0", out_valid);
    end
    tests_run++;
    if (xfer_cnt !== 8'd4 || ones_cnt !== 8'd4 || all_ones !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_stats: got xfer=%0d ones=%0d all=%b want 4 4 1", xfer_cnt, ones_cnt, all_ones);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 2'b01;
    step();
    in_data = 2'b10;
    step();
    tests_run++;
    if (in_ready !== 1'b0 || out_data !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_full: got rdy=%b d=%b want rdy=0 d=01", in_ready, out_data);
    end
    in_data = 2'b11;
    step();
    tests_run++;
    if (in_ready !== 1'b0 || out_data !== 2'b01 || xfer_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL bp_hold: got rdy=%b d=%b xfer=%0d want 0 01 2", in_ready, out_data, xfer_cnt);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'b10 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_pop1: got v=%b d=%b rdy=%b want 1 10 1", out_valid, out_data, in_ready);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'b11) begin
      tests_failed++;
      $display("FAIL bp_pop2: got v=%b d=%b want 1 11", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || xfer_cnt !== 8'd3 || ones_cnt !== 8'd4) begin
      tests_failed++;
      $display("FAIL bp_drain: got v=%b xfer=%0d ones=%0d want 0 3 4", out_valid, xfer_cnt, ones_cnt);
    end
  endtask

  task automatic test_accept_pop();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 2'b10;
    step();
    in_data = 2'b01;
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'b01 || in_ready !== 1'b1 || xfer_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL accept_pop: got v=%b d=%b rdy=%b xfer=%0d want 1 01 1 2", out_valid, out_data, in_ready, xfer_cnt);
    end
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || all_ones !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_pop_drain: got v=%b all=%b want 0 0", out_valid, all_ones);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    s_out_ready = 1'b1;
    s_in_valid = 1'b1;
    s_in_data = 2'b11;
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (s_xfer_cnt !== 3'd5 || s_ones_cnt !== 3'd7) begin
      tests_failed++;
      $display("FAIL sat_five: got xfer=%0d ones=%0d want 5 7", s_xfer_cnt, s_ones_cnt);
    end
    for (int i = 0; i < 3; i++) step();
    s_in_valid = 1'b0;
    tests_run++;
    if (s_xfer_cnt !== 3'd7 || s_ones_cnt !== 3'd7 || s_all_ones !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_hold: got xfer=%0d ones=%0d all=%b want 7 7 1", s_xfer_cnt, s_ones_cnt, s_all_ones);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 2'b01;
    step();
    in_data = 2'b10;
    step();
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_full: got rdy=%b v=%b want 0 1", in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_cnt !== 8'd0 || ones_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_async: got v=%b rdy=%b xfer=%0d ones=%0d want 0 1 0 0", out_valid, in_ready, xfer_cnt, ones_cnt);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 2'b10;
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'b10 || xfer_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL mid_restart: got v=%b d=%b xfer=%0d want 1 10 1", out_valid, out_data, xfer_cnt);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_accept_pop();
    test_saturation();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
